// File: rtl/core_mem_port.sv
// Per-core requester: turns a single-beat core load/store into the arbiter's level-held rden/wren
// handshake. Optional grant-wait timeout enabled by defining MEMPORT_TIMEOUT_EN.
module core_mem_port #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned HOLD_CYCLES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic              mem_acq,
  input  logic [DATA_W-1:0] mem_dq
);

  typedef enum logic [2:0] {StIdle, StReq, StHold, StDrain, StResp} state_e;

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rden_q, rden_d;
  logic              wren_q, wren_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              resp_valid_q, resp_valid_d;

`ifdef MEMPORT_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;
  logic            resp_err_q, resp_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    rden_d       = rden_q;
    wren_d       = wren_q;
    we_d         = we_q;
    addr_d       = addr_q;
    din_d        = din_q;
    rdata_d      = rdata_q;
    hold_cnt_d   = hold_cnt_q;
    resp_valid_d = 1'b0;
`ifdef MEMPORT_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
    resp_err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // ready_q is low on the first cycle out of reset, so no accept then
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          din_d   = req_wdata;
          we_d    = req_we;
          rden_d  = ~req_we;
          wren_d  = req_we;
          state_d = StReq;
`ifdef MEMPORT_TIMEOUT_EN
          tmo_cnt_d = '0;
          err_d     = 1'b0;
`endif
        end
      end
      StReq: begin
        if (mem_acq) begin
          hold_cnt_d = '0;
          state_d    = StHold;
        end
`ifdef MEMPORT_TIMEOUT_EN
        else if (tmo_cnt_q == TmoLast) begin
          rden_d  = 1'b0;
          wren_d  = 1'b0;
          err_d   = 1'b1;
          state_d = StDrain;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      StHold: begin
        // A dropped acq here is a protocol violation; keep counting regardless
        hold_cnt_d = hold_cnt_q + 4'd1;
        if (hold_cnt_q == HoldLast) begin
          if (!we_q) rdata_d = mem_dq;
          rden_d  = 1'b0;
          wren_d  = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!mem_acq) begin
          resp_valid_d = 1'b1;
          state_d      = StResp;
`ifdef MEMPORT_TIMEOUT_EN
          resp_err_d   = err_q;
`endif
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      rden_q       <= 1'b0;
      wren_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      rdata_q      <= '0;
      hold_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
`ifdef MEMPORT_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      rden_q       <= rden_d;
      wren_q       <= wren_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rdata_q      <= rdata_d;
      hold_cnt_q   <= hold_cnt_d;
      resp_valid_q <= resp_valid_d;
`ifdef MEMPORT_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign mem_rden   = rden_q;
  assign mem_wren   = wren_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
`ifdef MEMPORT_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_port.sv
// Scoreboard bench for core_mem_port with a small registered arbiter model driving acq/dq.
module tb_core_mem_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_err;
  logic [7:0] resp_rdata;
  logic       mem_rden, mem_wren;
  logic [7:0] mem_addr, mem_din;
  logic       mem_acq = 1'b0;
  logic [7:0] mem_dq;

  always #5 clk = ~clk;

  core_mem_port #(
    .ADDR_W        (8),
    .DATA_W        (8),
    .HOLD_CYCLES   (3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_rden  (mem_rden),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_acq   (mem_acq),
    .mem_dq    (mem_dq)
  );

  // Arbiter model: grants after grant_delay held cycles, drops acq one cycle after request removal
  int unsigned grant_delay = 1;
  bit          arb_en = 1'b1;
  int unsigned wait_cnt = 0;
  logic [7:0]  dq_val = 8'h00;

  always @(posedge clk) begin
    if (!(mem_rden || mem_wren)) begin
      mem_acq  <= 1'b0;
      wait_cnt <= 0;
    end else if (arb_en && wait_cnt >= grant_delay) begin
      mem_acq <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  assign mem_dq = mem_acq ? dq_val : 8'h00;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_resp = 0;
  int   n_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic expect_resp(input logic [7:0] d, input logic e);
    exp_t t;
    t.rdata = d;
    t.err   = e;
    exp_q.push_back(t);
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("rden_wren_exclusive", 32'(mem_rden && mem_wren), 32'd0);
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
          chk("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  // Accept monitor: values read here are the pre-edge ones the DUT samples
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      n_acc++;
      chk("accept_while_acq", 32'(mem_acq), 32'd0);
    end
  end

  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 300 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0;
    int a0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rden", 32'(mem_rden), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // 1: load 0x2A, grant 2 cycles after rden, dq = 0x5C
    dq_val      = 8'h5C;
    grant_delay = 1;
    expect_resp(8'h5C, 1'b0);
    issue(1'b0, 8'h2A, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t1_rden", 32'(mem_rden), 32'(k <= 6));
      chk("t1_resp_valid", 32'(resp_valid), 32'(k == 9));
      chk("t1_ready", 32'(req_ready), 32'(k == 10));
      if (k == 1) chk("t1_addr", 32'(mem_addr), 32'h2A);
    end
    wait_resp("t1_drain", 20);

    // 2: store 0xA5 to 0x10; dq must not be captured
    dq_val = 8'hEE;
    expect_resp(8'h5C, 1'b0);
    issue(1'b1, 8'h10, 8'hA5);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t2_wren", 32'(mem_wren), 32'(k <= 6));
      chk("t2_rden", 32'(mem_rden), 32'd0);
      chk("t2_addr", 32'(mem_addr), 32'h10);
      chk("t2_din", 32'(mem_din), 32'hA5);
    end
    wait_resp("t2_drain", 20);
    chk("t2_addr_stable", 32'(mem_addr), 32'h10);

    // 3: arbiter busy for 20 cycles
    dq_val      = 8'h3C;
    grant_delay = 20;
    r0          = n_resp;
    expect_resp(8'h3C, 1'b0);
    issue(1'b0, 8'h44, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("t3_rden_held", 32'(mem_rden), 32'd1);
      chk("t3_ready_low", 32'(req_ready), 32'd0);
    end
    wait_resp("t3_drain", 100);
    repeat (5) @(negedge clk);
    chk("t3_one_resp", 32'(n_resp - r0), 32'd1);

    // 4: asynchronous reset during HOLD
    grant_delay = 1;
    dq_val      = 8'h99;
    r0          = n_resp;
    issue(1'b0, 8'h55, 8'h00);
    repeat (4) @(negedge clk);
    chk("t4_rden_in_hold", 32'(mem_rden), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rden_async", 32'(mem_rden), 32'd0);
    chk("t4_wren_async", 32'(mem_wren), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_ready_after_rst", 32'(req_ready), 32'd1);
    chk("t4_rdata_cleared", 32'(resp_rdata), 32'd0);
    repeat (15) @(negedge clk);
    chk("t4_no_resp", 32'(n_resp - r0), 32'd0);

    // 5: req_valid held high for three loads
    dq_val = 8'h77;
    a0     = n_acc;
    for (int i = 0; i < 3; i++) expect_resp(8'h77, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h60;
    for (int i = 0; i < 300 && (n_acc - a0) < 3; i++) @(negedge clk);
    req_valid = 1'b0;
    chk("t5_accepts", 32'(n_acc - a0), 32'd3);
    wait_resp("t5_drain", 100);
    chk("t5_accepts_final", 32'(n_acc - a0), 32'd3);

    // 6: grant never arrives
    arb_en = 1'b0;
`ifdef MEMPORT_TIMEOUT_EN
    expect_resp(8'h77, 1'b1);
    issue(1'b0, 8'h70, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t6_rden", 32'(mem_rden), 32'(k <= 8));
      chk("t6_resp_valid", 32'(resp_valid), 32'(k == 10));
    end
    wait_resp("t6_drain", 20);
    arb_en = 1'b1;
`else
    r0 = n_resp;
    issue(1'b0, 8'h70, 8'h00);
    repeat (100) @(negedge clk);
    chk("t6_rden_held", 32'(mem_rden), 32'd1);
    chk("t6_ready_low", 32'(req_ready), 32'd0);
    chk("t6_no_resp", 32'(n_resp - r0), 32'd0);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
